// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: shared SPI engine state codes and arbiter FSM states
package adc_spi_pkg;
    localparam logic [2:0] SPI_IDLE = 3'd0;
    localparam logic [2:0] SPI_DONE = 3'd4;
    typedef enum logic [2:0] {IDLE, START, WAIT_DONE, RESP, RELEASE} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority encoder searching from ptr+1 with wrap
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    idx
);
    logic          found;
    logic [IW-1:0] k;
    // first requester after ptr wins; ptr itself is checked last
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            k = IW'((int'(ptr) + i) % N_REQ);
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                idx    = k;
            end
        end
    end
endmodule

// File: rtl/adc_spi_rr_arbiter.sv
// adc_spi_rr_arbiter: round-robin sharing of one SPI engine with timeout recovery
module adc_spi_rr_arbiter
    import adc_spi_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 1023
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [N_REQ-1:0]            i_req,
    input  logic [N_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [N_REQ-1:0]            o_gnt,
    output logic [N_REQ-1:0]            o_rsp_valid,
    output logic [DATA_WIDTH-1:0]       o_rsp_data,
    output logic                        o_rsp_err,
    output logic [$clog2(N_REQ)-1:0]    o_cur_id,
    output logic                        o_busy,
    output logic                        o_spi_start,
    output logic [DATA_WIDTH-1:0]       o_spi_data,
    input  logic [2:0]                  i_spi_state,
    input  logic [DATA_WIDTH-1:0]       i_spi_miso_data
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t      state, state_n;
    logic [IW-1:0]    rr_ptr;
    logic [CW-1:0]    cnt;
    logic [N_REQ-1:0] pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             timed;
    logic             timeout;
    logic             can_grant;

    rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req(i_req),
        .ptr(rr_ptr),
        .gnt(pick_gnt),
        .idx(pick_idx)
    );

    assign timed     = (state == START) || (state == WAIT_DONE);
    assign timeout   = timed && (cnt == CW'(TIMEOUT - 1));
    assign can_grant = (|i_req) && (i_spi_state == SPI_IDLE);
    assign o_busy    = state != IDLE;

    // state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_n;
    end

    // next state; a timeout preempts any engine handshake
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = can_grant ? START : IDLE;
            START:     state_n = timeout ? RESP : (i_spi_state != SPI_IDLE) ? WAIT_DONE : START;
            WAIT_DONE: state_n = (timeout || i_spi_state == SPI_DONE) ? RESP : WAIT_DONE;
            RESP:      state_n = o_rsp_err ? IDLE : RELEASE;
            RELEASE:   state_n = (i_spi_state == SPI_IDLE) ? IDLE : RELEASE;
            default:   state_n = IDLE;
        endcase
    end

    // timeout counter restarts on every entry into START or WAIT_DONE
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) cnt <= '0;
        else       cnt <= (timed && state_n == state) ? cnt + CW'(1) : '0;
    end

    // grant, SPI handoff and response registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_gnt       <= '0;
            o_cur_id    <= '0;
            rr_ptr      <= IW'(N_REQ - 1);
            o_spi_data  <= '0;
            o_spi_start <= 1'b0;
            o_rsp_valid <= '0;
            o_rsp_data  <= '0;
            o_rsp_err   <= 1'b0;
        end else begin
            if (state == IDLE && state_n == START) begin
                o_gnt       <= pick_gnt;
                o_cur_id    <= pick_idx;
                rr_ptr      <= pick_idx;
                o_spi_data  <= i_req_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                o_spi_start <= 1'b1;
            end
            if (state == START && state_n != START) o_spi_start <= 1'b0;
            if (state_n == RESP) begin
                o_gnt       <= '0;
                o_rsp_valid <= o_gnt;
                o_rsp_err   <= timeout;
                o_rsp_data  <= timeout ? '0 : i_spi_miso_data;
            end else begin
                o_rsp_valid <= '0;
                o_rsp_err   <= 1'b0;
                o_rsp_data  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_adc_spi_rr_arbiter.sv
// tb_adc_spi_rr_arbiter: directed checks of grant order, data path, timeouts and reset
module tb_adc_spi_rr_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [63:0] req_data = '0;
    logic [3:0]  o_gnt, o_rsp_valid;
    logic [15:0] o_rsp_data, o_spi_data;
    logic        o_rsp_err, o_busy, o_spi_start;
    logic [1:0]  o_cur_id;
    logic [2:0]  spi_state;
    logic [15:0] miso;

    int          n_chk = 0;
    int          n_fail = 0;
    int          mode = 0;
    int          lat = 3;
    int          ecnt = 0;
    logic [15:0] eng_xor = 16'hB791;
    int          order2 [5] = '{0, 1, 2, 3, 0};
    int          order3 [4] = '{0, 2, 0, 2};

    adc_spi_rr_arbiter dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_data(req_data),
        .o_gnt(o_gnt), .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
        .o_rsp_err(o_rsp_err), .o_cur_id(o_cur_id), .o_busy(o_busy),
        .o_spi_start(o_spi_start), .o_spi_data(o_spi_data),
        .i_spi_state(spi_state), .i_spi_miso_data(miso)
    );

    always #5 clk = ~clk;

    // engine model: mode 0 normal, 1 stuck idle, 2 busy forever
    initial begin
        spi_state = 3'd0;
        miso = '0;
        forever begin
            @(negedge clk);
            if (mode == 1) spi_state = 3'd0;
            else if (spi_state == 3'd0) begin
                if (o_spi_start) begin spi_state = 3'd1; ecnt = 0; end
            end else if (spi_state == 3'd4) spi_state = 3'd0;
            else begin
                ecnt++;
                if (mode == 0 && ecnt >= lat) begin spi_state = 3'd4; miso = o_spi_data ^ eng_xor; end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(input int max);
        int n = 0;
        while (o_gnt == 0 && n < max) begin @(negedge clk); n++; end
        chk("gnt_wait_bound", 32'(n < max), 1);
    endtask

    task automatic wait_rsp(input int max);
        int n = 0;
        while (o_rsp_valid == 0 && n < max) begin @(negedge clk); n++; end
        chk("rsp_wait_bound", 32'(n < max), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int  n;
        logic seen;
        // reset state
        @(negedge clk);
        chk("rst_gnt", o_gnt, 0);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_start", o_spi_start, 0);
        chk("rst_spi_data", o_spi_data, 0);
        chk("rst_cur_id", o_cur_id, 0);
        chk("rst_rsp_err", o_rsp_err, 0);
        rst = 1'b0;
        @(negedge clk);
        // 1: single request, 40-cycle engine
        lat = 40;
        req = 4'b0100;
        req_data[47:32] = 16'hA5A5;
        @(negedge clk);
        chk("t1_gnt", o_gnt, 4'b0100);
        chk("t1_start", o_spi_start, 1);
        chk("t1_spi_data", o_spi_data, 16'hA5A5);
        chk("t1_cur_id", o_cur_id, 2);
        chk("t1_busy", o_busy, 1);
        req = 4'b0000;
        req_data[47:32] = 16'h0F0F;
        wait_rsp(100);
        chk("t1_rsp_valid", o_rsp_valid, 4'b0100);
        chk("t1_rsp_data", o_rsp_data, 16'h1234);
        chk("t1_rsp_err", o_rsp_err, 0);
        chk("t1_gnt_clear", o_gnt, 0);
        chk("t1_spi_data_held", o_spi_data, 16'hA5A5);
        @(negedge clk);
        chk("t1_rsp_pulse", o_rsp_valid, 0);
        repeat (4) @(negedge clk);
        chk("t1_idle", o_busy, 0);
        // 2: all requesting after reset
        do_reset();
        lat = 3;
        eng_xor = 16'h00FF;
        req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_gnt(50);
            chk("t2_gnt", o_gnt, 32'(1) << order2[i]);
            chk("t2_spi_data", o_spi_data, req_data[order2[i]*16 +: 16]);
            wait_rsp(50);
            chk("t2_rsp_valid", o_rsp_valid, 32'(1) << order2[i]);
            chk("t2_rsp_data", o_rsp_data, req_data[order2[i]*16 +: 16] ^ 16'h00FF);
        end
        req = 4'b0000;
        repeat (6) @(negedge clk);
        // 3: requester 0 re-requests after each response, requester 2 pending
        do_reset();
        req = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(50);
            chk("t3_gnt", o_gnt, 32'(1) << order3[i]);
            req = 4'b0101 & ~o_gnt;
            wait_rsp(50);
            chk("t3_rsp_valid", o_rsp_valid, 32'(1) << order3[i]);
            req = 4'b0101;
        end
        req = 4'b0000;
        repeat (6) @(negedge clk);
        // 4: engine stuck idle -> start timeout
        do_reset();
        mode = 1;
        req = 4'b0010;
        @(negedge clk);
        chk("t4_gnt", o_gnt, 4'b0010);
        req = 4'b0000;
        n = 0;
        while (o_spi_start && n < 2000) begin n++; @(negedge clk); end
        chk("t4_start_cycles", n, 1023);
        chk("t4_rsp_valid", o_rsp_valid, 4'b0010);
        chk("t4_rsp_err", o_rsp_err, 1);
        chk("t4_rsp_data", o_rsp_data, 0);
        @(negedge clk);
        chk("t4_back_idle", o_busy, 0);
        mode = 0;
        req = 4'b1000;
        @(negedge clk);
        chk("t4_next_gnt", o_gnt, 4'b1000);
        req = 4'b0000;
        wait_rsp(50);
        chk("t4_next_err", o_rsp_err, 0);
        chk("t4_next_data", o_rsp_data, 16'h4444 ^ 16'h00FF);
        repeat (6) @(negedge clk);
        // 5: engine stuck busy -> wait timeout, then no start while engine busy
        mode = 2;
        req = 4'b0001;
        wait_gnt(10);
        chk("t5_gnt", o_gnt, 4'b0001);
        req = 4'b0000;
        wait_rsp(1200);
        chk("t5_rsp_valid", o_rsp_valid, 4'b0001);
        chk("t5_rsp_err", o_rsp_err, 1);
        chk("t5_rsp_data", o_rsp_data, 0);
        req = 4'b0010;
        repeat (10) @(negedge clk);
        chk("t5_no_start", o_spi_start, 0);
        chk("t5_no_gnt", o_gnt, 0);
        mode = 0;
        wait_gnt(20);
        chk("t5_late_gnt", o_gnt, 4'b0010);
        req = 4'b0000;
        wait_rsp(50);
        chk("t5_late_err", o_rsp_err, 0);
        repeat (6) @(negedge clk);
        // 6: reset during WAIT_DONE
        lat = 40;
        req = 4'b0100;
        wait_gnt(10);
        chk("t6_gnt", o_gnt, 4'b0100);
        req = 4'b0000;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_rst_gnt", o_gnt, 0);
        chk("t6_rst_busy", o_busy, 0);
        chk("t6_rst_spi_data", o_spi_data, 0);
        chk("t6_rst_cur_id", o_cur_id, 0);
        seen = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (o_rsp_valid != 0) seen = 1'b1;
        end
        chk("t6_no_rsp", seen, 0);
        lat = 3;
        req = 4'b0001;
        @(negedge clk);
        chk("t6_regrant", o_gnt, 4'b0001);
        req = 4'b0000;
        wait_rsp(50);
        chk("t6_rsp_valid", o_rsp_valid, 4'b0001);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
